// File: rtl/cmd_phys_layer.sv
// SD host CMD-line physical stage.
//
// Latches a 40-bit command token, appends CRC7 and an end bit, and shifts the 48-bit frame
// out MSB-first. It then waits for the card's response start bit and shifts in a 48- or
// 136-bit response. The result goes back to the controller with a strobe/ack handshake.
//
// Ports:
//   clock, reset     SD clock (posedge) and synchronous active-high reset
//   strobe_in        command valid, held by the controller until ack_out
//   ack_in           controller has consumed the response
//   idle_in          controller idle; high outside IDLE aborts back to IDLE
//   cmd_to_send      {2'b01, index[5:0], argument[31:0]}
//   resp_type        0=none, 1=48-bit, 2=136-bit, 3=reserved (handled as none)
//   cmd_line_in      serial CMD line from the card
//   cmd_line_out     serial CMD line to the card (idles high)
//   cmd_oe           CMD line output enable
//   response         received frame, right-aligned
//   strobe_out       response/completion valid
//   ack_out          one-cycle acceptance of strobe_in
//   timeout          no start bit within RESP_TIMEOUT clocks
//   crc_error        received CRC7 mismatch
//
// Build option: define CMD_RESP_CRC_CHECK_EN to check the CRC7 of received responses.
// Without it, crc_error is tied low and no receive CRC logic exists.

module cmd_phys_layer #(
  parameter int unsigned RESP_TIMEOUT = 64,
  parameter int unsigned CNT_W        = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         strobe_in,
  input  logic         ack_in,
  input  logic         idle_in,
  input  logic [39:0]  cmd_to_send,
  input  logic [1:0]   resp_type,
  input  logic         cmd_line_in,
  output logic         cmd_line_out,
  output logic         cmd_oe,
  output logic [135:0] response,
  output logic         strobe_out,
  output logic         ack_out,
  output logic         timeout,
  output logic         crc_error
);

  typedef enum logic [2:0] {StIdle, StSend, StWaitResp, StRecv, StDone} state_e;

  state_e           state_q;
  logic [47:0]      frame_q;   // transmit shift register, MSB on the line next
  logic [1:0]       rtype_q;   // 0 means no response expected
  logic [CNT_W-1:0] cnt_q;     // bits sent, wait cycles, or bits received
  logic [134:0]     rx_sr_q;
  logic [135:0]     rx_next;
  logic [CNT_W-1:0] rx_last;

  // Serial CRC7, G(x) = x^7 + x^3 + 1, MSB first, zero init. Leading zeros leave the
  // register at zero, so shorter messages are right-aligned in the 120-bit input.
  function automatic logic [6:0] crc7(input logic [119:0] data);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = 119; i >= 0; i--) begin
      fb = data[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  assign rx_next = {rx_sr_q, cmd_line_in};
  // Index of the final bit: total frame length minus one, start bit counted.
  assign rx_last = (rtype_q == 2'd2) ? CNT_W'(135) : CNT_W'(47);

`ifdef CMD_RESP_CRC_CHECK_EN
  logic crc_err_q;
  logic rx_crc_bad;

  always_comb begin
    rx_crc_bad = 1'b0;
    if (rtype_q == 2'd2) begin
      rx_crc_bad = (crc7(rx_next[127:8]) != rx_next[7:1]);
    end else begin
      rx_crc_bad = (crc7({80'b0, rx_next[47:8]}) != rx_next[7:1]);
    end
  end

  assign crc_error = crc_err_q;
`else
  assign crc_error = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset || (idle_in && (state_q != StIdle))) begin
      state_q      <= StIdle;
      frame_q      <= '0;
      rtype_q      <= '0;
      cnt_q        <= '0;
      rx_sr_q      <= '0;
      cmd_line_out <= 1'b1;
      cmd_oe       <= 1'b0;
      response     <= '0;
      strobe_out   <= 1'b0;
      ack_out      <= 1'b0;
      timeout      <= 1'b0;
`ifdef CMD_RESP_CRC_CHECK_EN
      crc_err_q    <= 1'b0;
`endif
    end else begin
      ack_out <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (strobe_in) begin
            frame_q <= {cmd_to_send, crc7({80'b0, cmd_to_send}), 1'b1};
            rtype_q <= (resp_type == 2'd3) ? 2'd0 : resp_type;
            cnt_q   <= '0;
            ack_out <= 1'b1;
            state_q <= StSend;
          end
        end

        StSend: begin
          if (cnt_q == CNT_W'(48)) begin
            cmd_oe       <= 1'b0;
            cmd_line_out <= 1'b1;
            cnt_q        <= '0;
            if (rtype_q == 2'd0) begin
              strobe_out <= 1'b1;
              state_q    <= StDone;
            end else begin
              state_q <= StWaitResp;
            end
          end else begin
            cmd_oe       <= 1'b1;
            cmd_line_out <= frame_q[47];
            frame_q      <= {frame_q[46:0], 1'b1};
            cnt_q        <= cnt_q + 1'b1;
          end
        end

        StWaitResp: begin
          // A start bit seen on the last allowed cycle still wins over the timeout.
          if (!cmd_line_in) begin
            rx_sr_q <= {134'b0, cmd_line_in};
            cnt_q   <= CNT_W'(1);
            state_q <= StRecv;
          end else if (cnt_q == CNT_W'(RESP_TIMEOUT - 1)) begin
            timeout    <= 1'b1;
            strobe_out <= 1'b1;
            state_q    <= StDone;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        StRecv: begin
          rx_sr_q <= rx_next[134:0];
          if (cnt_q == rx_last) begin
            response   <= rx_next;
            strobe_out <= 1'b1;
            state_q    <= StDone;
`ifdef CMD_RESP_CRC_CHECK_EN
            crc_err_q  <= rx_crc_bad;
`endif
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        StDone: begin
          if (ack_in) begin
            strobe_out <= 1'b0;
            response   <= '0;
            timeout    <= 1'b0;
            cnt_q      <= '0;
`ifdef CMD_RESP_CRC_CHECK_EN
            crc_err_q  <= 1'b0;
`endif
            state_q    <= StIdle;
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_phys_layer.sv
module tb_cmd_phys_layer;

  localparam int unsigned RespTimeout = 64;

`ifdef CMD_RESP_CRC_CHECK_EN
  localparam bit CrcChk = 1'b1;
`else
  localparam bit CrcChk = 1'b0;
`endif

  logic         clock = 1'b0;
  logic         reset;
  logic         strobe_in;
  logic         ack_in;
  logic         idle_in;
  logic [39:0]  cmd_to_send;
  logic [1:0]   resp_type;
  logic         cmd_line_in;
  logic         cmd_line_out;
  logic         cmd_oe;
  logic [135:0] response;
  logic         strobe_out;
  logic         ack_out;
  logic         timeout;
  logic         crc_error;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  cmd_phys_layer #(
    .RESP_TIMEOUT(RespTimeout),
    .CNT_W       (8)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .strobe_in   (strobe_in),
    .ack_in      (ack_in),
    .idle_in     (idle_in),
    .cmd_to_send (cmd_to_send),
    .resp_type   (resp_type),
    .cmd_line_in (cmd_line_in),
    .cmd_line_out(cmd_line_out),
    .cmd_oe      (cmd_oe),
    .response    (response),
    .strobe_out  (strobe_out),
    .ack_out     (ack_out),
    .timeout     (timeout),
    .crc_error   (crc_error)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: got still running want finished");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reference CRC7 by polynomial long division: append 7 zeros, divide by 0x89.
  function automatic logic [6:0] ref_crc7(input logic [119:0] d);
    logic [126:0] rem;
    rem = {d, 7'b0};
    for (int i = 126; i >= 7; i--) begin
      if (rem[i]) rem[i -: 8] = rem[i -: 8] ^ 8'h89;
    end
    return rem[6:0];
  endfunction

  function automatic logic [47:0] make_frame(input logic [39:0] content);
    return {content, ref_crc7({80'b0, content}), 1'b1};
  endfunction

  function automatic logic [135:0] make_r2(input logic [119:0] payload);
    return {8'h3F, payload, ref_crc7(payload), 1'b1};
  endfunction

  // Presents a command, collects the serial frame; leaves time one cycle after the last bit.
  task automatic issue_cmd(input logic [39:0] tok, input logic [1:0] rt,
                           output logic [47:0] fr, output int oe_n, output int ack_n);
    fr = '0;
    oe_n = 0;
    ack_n = 0;
    cmd_to_send = tok;
    resp_type = rt;
    strobe_in = 1'b1;
    tick();
    if (ack_out) ack_n++;
    strobe_in = 1'b0;
    cmd_to_send = ~tok;
    resp_type = ~rt;
    for (int i = 0; i < 48; i++) begin
      tick();
      fr = {fr[46:0], cmd_line_out};
      if (cmd_oe) oe_n++;
      if (ack_out) ack_n++;
    end
    tick();
  endtask

  task automatic drive_resp(input logic [135:0] bits, input int n, input int delay);
    for (int d = 0; d < delay; d++) begin
      cmd_line_in = 1'b1;
      tick();
    end
    for (int i = n - 1; i >= 0; i--) begin
      cmd_line_in = bits[i];
      tick();
    end
    cmd_line_in = 1'b1;
  endtask

  task automatic release_done();
    ack_in = 1'b1;
    tick();
    ack_in = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    strobe_in = 1'b1;
    ack_in = 1'b0;
    idle_in = 1'b0;
    cmd_to_send = 40'h4000000000;
    resp_type = 2'd0;
    cmd_line_in = 1'b1;
    tick();
    tick();
    checks++;
    if ({cmd_line_out, cmd_oe, strobe_out, ack_out, timeout, crc_error} !== 6'b100000) begin
      errors++;
      $display("FAIL reset_outputs: got %b want 100000",
               {cmd_line_out, cmd_oe, strobe_out, ack_out, timeout, crc_error});
    end
    checks++;
    if (response !== 136'b0) begin
      errors++;
      $display("FAIL reset_response: got %h want 0", response);
    end
    strobe_in = 1'b0;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_cmd0();
    logic [47:0] fr;
    int oe_n, ack_n;
    issue_cmd(40'h4000000000, 2'd0, fr, oe_n, ack_n);
    checks++;
    if (ack_n !== 1) begin errors++; $display("FAIL cmd0_ack: got %0d want 1", ack_n); end
    checks++;
    if (fr !== 48'h400000000095) begin
      errors++; $display("FAIL cmd0_frame: got %h want 400000000095", fr);
    end
    checks++;
    if (oe_n !== 48) begin errors++; $display("FAIL cmd0_oe_len: got %0d want 48", oe_n); end
    checks++;
    if ({cmd_oe, cmd_line_out} !== 2'b01) begin
      errors++; $display("FAIL cmd0_line_after: got %b want 01", {cmd_oe, cmd_line_out});
    end
    checks++;
    if ({strobe_out, timeout, crc_error} !== 3'b100) begin
      errors++;
      $display("FAIL cmd0_done_at_49: got %b want 100", {strobe_out, timeout, crc_error});
    end
    tick();
    checks++;
    if (strobe_out !== 1'b1) begin errors++; $display("FAIL cmd0_hold: got 0 want 1"); end
    release_done();
    checks++;
    if (strobe_out !== 1'b0) begin errors++; $display("FAIL cmd0_release: got 1 want 0"); end
  endtask

  task automatic test_cmd8();
    logic [47:0] fr, r7;
    int oe_n, ack_n;
    issue_cmd(40'h48000001AA, 2'd1, fr, oe_n, ack_n);
    checks++;
    if (fr !== 48'h48000001AA87) begin
      errors++; $display("FAIL cmd8_frame: got %h want 48000001aa87", fr);
    end
    r7 = make_frame(40'h08000001AA);
    drive_resp({88'b0, r7}, 48, 2);
    checks++;
    if (strobe_out !== 1'b1) begin errors++; $display("FAIL cmd8_strobe: got 0 want 1"); end
    checks++;
    if (response !== {88'b0, r7}) begin
      errors++; $display("FAIL cmd8_response: got %h want %h", response, {88'b0, r7});
    end
    checks++;
    if ({timeout, crc_error} !== 2'b00) begin
      errors++; $display("FAIL cmd8_flags: got %b want 00", {timeout, crc_error});
    end
    release_done();
  endtask

  task automatic test_cmd17_timeout();
    logic [47:0] fr;
    int oe_n, ack_n, n;
    issue_cmd(40'h5100000000, 2'd1, fr, oe_n, ack_n);
    checks++;
    if (fr !== make_frame(40'h5100000000) || fr[7:0] !== 8'h55) begin
      errors++; $display("FAIL cmd17_frame: got %h want %h", fr, make_frame(40'h5100000000));
    end
    n = 0;
    while (!strobe_out && n < 4 * RespTimeout) begin
      tick();
      n++;
    end
    checks++;
    if (n !== RespTimeout) begin
      errors++; $display("FAIL cmd17_timeout_cycles: got %0d want %0d", n, RespTimeout);
    end
    checks++;
    if ({timeout, crc_error} !== 2'b10 || response !== 136'b0) begin
      errors++;
      $display("FAIL cmd17_timeout_flags: got %b/%h want 10/0", {timeout, crc_error}, response);
    end
    release_done();
  endtask

  task automatic test_cmd2();
    logic [47:0] fr;
    logic [127:0] rnd;
    logic [135:0] r2, bad;
    int oe_n, ack_n;
    issue_cmd({2'b01, 6'd2, 32'h0}, 2'd2, fr, oe_n, ack_n);
    checks++;
    if (fr !== make_frame({2'b01, 6'd2, 32'h0})) begin
      errors++; $display("FAIL cmd2_frame: got %h want %h", fr, make_frame({2'b01, 6'd2, 32'h0}));
    end
    rnd = {$urandom, $urandom, $urandom, $urandom};
    r2 = make_r2(rnd[119:0]);
    drive_resp(r2, 136, 5);
    checks++;
    if (strobe_out !== 1'b1 || response !== r2) begin
      errors++; $display("FAIL cmd2_response: got %b/%h want 1/%h", strobe_out, response, r2);
    end
    checks++;
    if ({timeout, crc_error} !== 2'b00) begin
      errors++; $display("FAIL cmd2_flags: got %b want 00", {timeout, crc_error});
    end
    release_done();
    issue_cmd({2'b01, 6'd2, 32'h0}, 2'd2, fr, oe_n, ack_n);
    bad = r2 ^ (136'b1 << (1 + $urandom_range(0, 6)));
    drive_resp(bad, 136, 0);
    checks++;
    if (response !== bad) begin
      errors++; $display("FAIL cmd2_bad_response: got %h want %h", response, bad);
    end
    checks++;
    if (crc_error !== CrcChk) begin
      errors++; $display("FAIL cmd2_crc_error: got %b want %b", crc_error, CrcChk);
    end
    release_done();
  endtask

  task automatic test_random();
    logic [39:0] tok, content;
    logic [47:0] fr, r1;
    logic [127:0] rnd;
    logic [135:0] exp_resp;
    logic [1:0] rt;
    logic exp_crc;
    int oe_n, ack_n, n;
    for (int it = 0; it < 10; it++) begin
      rt = 2'($urandom_range(0, 3));
      tok = {2'b01, 6'($urandom_range(0, 63)), 32'($urandom)};
      issue_cmd(tok, rt, fr, oe_n, ack_n);
      checks++;
      if (fr !== make_frame(tok) || oe_n !== 48 || ack_n !== 1) begin
        errors++;
        $display("FAIL rand_frame[%0d]: got %h oe=%0d ack=%0d want %h oe=48 ack=1",
                 it, fr, oe_n, ack_n, make_frame(tok));
      end
      if (rt == 2'd1 || rt == 2'd2) begin
        rnd = {$urandom, $urandom, $urandom, $urandom};
        if (rt == 2'd1) begin
          content = {1'b0, rnd[38:0]};
          r1 = make_frame(content);
          if ($urandom_range(0, 2) == 0) r1[1 + $urandom_range(0, 6)] ^= 1'b1;
          r1[0] = rnd[100];  // end bit is not checked by the receiver
          exp_resp = {88'b0, r1};
          exp_crc = CrcChk && (ref_crc7({80'b0, r1[47:8]}) != r1[7:1]);
          drive_resp(exp_resp, 48, $urandom_range(0, 40));
        end else begin
          exp_resp = make_r2(rnd[119:0]);
          if ($urandom_range(0, 2) == 0) exp_resp[1 + $urandom_range(0, 6)] ^= 1'b1;
          exp_crc = CrcChk && (ref_crc7(exp_resp[127:8]) != exp_resp[7:1]);
          drive_resp(exp_resp, 136, $urandom_range(0, 40));
        end
        checks++;
        if ({strobe_out, timeout, crc_error} !== {2'b10, exp_crc} || response !== exp_resp) begin
          errors++;
          $display("FAIL rand_resp[%0d]: got %b %h want %b %h", it,
                   {strobe_out, timeout, crc_error}, response, {2'b10, exp_crc}, exp_resp);
        end
      end else begin
        checks++;
        if ({strobe_out, timeout, crc_error} !== 3'b100 || response !== 136'b0) begin
          errors++;
          $display("FAIL rand_noresp[%0d]: got %b %h want 100 0", it,
                   {strobe_out, timeout, crc_error}, response);
        end
      end
      release_done();
    end
  endtask

  task automatic test_abort();
    logic [47:0] fr;
    int oe_n, ack_n, busy;
    cmd_to_send = 40'h4000000000;
    resp_type = 2'd0;
    strobe_in = 1'b1;
    tick();
    strobe_in = 1'b0;
    repeat (5) tick();
    checks++;
    if (cmd_oe !== 1'b1) begin errors++; $display("FAIL abort_pre_send: got 0 want 1"); end
    idle_in = 1'b1;
    tick();
    idle_in = 1'b0;
    checks++;
    if ({cmd_oe, cmd_line_out, ack_out} !== 3'b010) begin
      errors++;
      $display("FAIL abort_send: got %b want 010", {cmd_oe, cmd_line_out, ack_out});
    end
    busy = 0;
    repeat (60) begin
      tick();
      if (cmd_oe || strobe_out) busy++;
    end
    checks++;
    if (busy !== 0) begin errors++; $display("FAIL abort_no_resume: got %0d want 0", busy); end
    // Abort while waiting for a response.
    issue_cmd(40'h48000001AA, 2'd1, fr, oe_n, ack_n);
    repeat (10) tick();
    idle_in = 1'b1;
    tick();
    idle_in = 1'b0;
    busy = 0;
    repeat (80) begin
      tick();
      if (strobe_out) busy++;
    end
    checks++;
    if (busy !== 0) begin errors++; $display("FAIL abort_wait: got %0d want 0", busy); end
    // Abort in DONE, then a normal command still works.
    issue_cmd(40'h4000000000, 2'd0, fr, oe_n, ack_n);
    idle_in = 1'b1;
    tick();
    idle_in = 1'b0;
    checks++;
    if (strobe_out !== 1'b0) begin errors++; $display("FAIL abort_done: got 1 want 0"); end
    issue_cmd(40'h5100000000, 2'd0, fr, oe_n, ack_n);
    checks++;
    if (fr !== make_frame(40'h5100000000) || strobe_out !== 1'b1) begin
      errors++;
      $display("FAIL abort_recover: got %h/%b want %h/1", fr, strobe_out,
               make_frame(40'h5100000000));
    end
    release_done();
  endtask

  task automatic test_back_to_back();
    int acks;
    cmd_to_send = 40'h4000000000;
    resp_type = 2'd0;
    strobe_in = 1'b1;
    tick();
    checks++;
    if (ack_out !== 1'b1) begin errors++; $display("FAIL b2b_first_ack: got 0 want 1"); end
    acks = 0;
    repeat (52) begin
      tick();
      if (ack_out) acks++;
    end
    checks++;
    if (acks !== 0 || strobe_out !== 1'b1) begin
      errors++; $display("FAIL b2b_held: got acks=%0d strobe=%b want 0/1", acks, strobe_out);
    end
    ack_in = 1'b1;
    tick();
    ack_in = 1'b0;
    checks++;
    if ({strobe_out, ack_out} !== 2'b00) begin
      errors++; $display("FAIL b2b_release: got %b want 00", {strobe_out, ack_out});
    end
    tick();
    checks++;
    if (ack_out !== 1'b1) begin errors++; $display("FAIL b2b_second_ack: got 0 want 1"); end
    strobe_in = 1'b0;
    idle_in = 1'b1;
    tick();
    idle_in = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_frame();
    int busy;
    cmd_to_send = 40'h48000001AA;
    resp_type = 2'd1;
    strobe_in = 1'b1;
    tick();
    strobe_in = 1'b0;
    repeat (10) tick();
    reset = 1'b1;
    tick();
    checks++;
    if ({cmd_oe, cmd_line_out, strobe_out, ack_out} !== 4'b0100) begin
      errors++;
      $display("FAIL reset_mid: got %b want 0100", {cmd_oe, cmd_line_out, strobe_out, ack_out});
    end
    reset = 1'b0;
    busy = 0;
    repeat (60) begin
      tick();
      if (cmd_oe || strobe_out) busy++;
    end
    checks++;
    if (busy !== 0) begin errors++; $display("FAIL reset_mid_quiet: got %0d want 0", busy); end
  endtask

  initial begin
    test_reset();
    test_cmd0();
    test_cmd8();
    test_cmd17_timeout();
    test_cmd2();
    test_random();
    test_abort();
    test_back_to_back();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
